// File: rtl/mux_rr_reg_if.sv
// Handshake bundle between the upstream channels, the registered mux and its consumer.
// The master side drives channel data, mode/select and downstream ready. The slave side is the mux.
interface mux_rr_reg_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
);
    logic [NCH*WIDTH-1:0] din;
    logic [NCH-1:0]       din_valid;
    logic [NCH-1:0]       din_ready;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [WIDTH-1:0]     mux_out;
    logic                 mux_valid;
    logic                 mux_ready;
    logic [SELW-1:0]      mux_ch;

    modport master (
        output din, din_valid, mode, sel, mux_ready,
        input  din_ready, mux_out, mux_valid, mux_ch
    );

    modport slave (
        input  din, din_valid, mode, sel, mux_ready,
        output din_ready, mux_out, mux_valid, mux_ch
    );
endinterface

// File: rtl/mux_rr_reg.sv
// Registered N:1 channel mux with valid/ready handshakes.
// The channel is chosen either by a fixed select or by round-robin arbitration.
module mux_rr_reg #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    mux_rr_reg_if.slave  bus
);
    logic                 load_en;
    logic                 grant_ok;
    logic                 in_xfer;
    logic [SELW-1:0]      grant;
    logic [SELW-1:0]      rr_ptr;
    logic [SELW-1:0]      rr_hi;
    logic [SELW-1:0]      rr_lo;
    logic                 rr_hi_found;
    logic                 rr_lo_found;
    logic [NCH-1:0]       ready;
    logic [WIDTH-1:0]     grant_data;
    logic [WIDTH-1:0]     out_q;
    logic                 valid_q;
    logic [SELW-1:0]      ch_q;

    assign load_en = !valid_q || bus.mux_ready;

    // Rotating search split in two passes: channels above rr_ptr win first, else the lowest valid.
    always_comb begin
        rr_hi       = '0;
        rr_lo       = '0;
        rr_hi_found = 1'b0;
        rr_lo_found = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (bus.din_valid[k]) begin
                rr_lo_found = 1'b1;
                rr_lo       = SELW'(k);
                if (k > int'(rr_ptr)) begin
                    rr_hi_found = 1'b1;
                    rr_hi       = SELW'(k);
                end
            end
        end
    end

    always_comb begin
        grant    = '0;
        grant_ok = 1'b0;
        if (bus.mode) begin
            grant_ok = rr_hi_found || rr_lo_found;
            grant    = rr_hi_found ? rr_hi : rr_lo;
        end else if (int'(bus.sel) < NCH) begin
            grant_ok = 1'b1;
            grant    = bus.sel;
        end
    end

    // Fixed mode offers ready on the selected channel whether or not it is valid.
    always_comb begin
        ready      = '0;
        grant_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (int'(grant) == k) begin
                grant_data = bus.din[k*WIDTH +: WIDTH];
                if (reset_n && load_en && grant_ok) begin
                    ready[k] = 1'b1;
                end
            end
        end
    end

    assign in_xfer = |(ready & bus.din_valid);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            ch_q    <= '0;
            rr_ptr  <= SELW'(NCH - 1);
        end else if (load_en) begin
            if (in_xfer) begin
                out_q   <= grant_data;
                ch_q    <= grant;
                valid_q <= 1'b1;
                if (bus.mode) begin
                    rr_ptr <= grant;
                end
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.din_ready = ready;
    assign bus.mux_out   = out_q;
    assign bus.mux_valid = valid_q;
    assign bus.mux_ch    = ch_q;
endmodule

// File: tb/tb_mux_rr_reg.sv
// Directed and randomized checks of mux_rr_reg against a behavioural arbitration model.
module tb_mux_rr_reg;
    localparam int W = 8;
    localparam int N = 4;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    int         m_ptr;
    logic       m_valid;
    logic [7:0] m_out;
    int         m_ch;

    mux_rr_reg_if #(.WIDTH(W), .NCH(N), .SELW(2)) bus ();
    mux_rr_reg_if #(.WIDTH(W), .NCH(N), .SELW(3)) bus2 ();

    mux_rr_reg #(.WIDTH(W), .NCH(N), .SELW(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    mux_rr_reg #(.WIDTH(W), .NCH(N), .SELW(3)) dut_wide (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr   = N - 1;
        m_valid = 1'b0;
        m_out   = 8'h00;
        m_ch    = 0;
    endtask

    // Which channel gets ready this cycle, derived from the arbitration rules; -1 means none.
    task automatic model_grant(output logic [3:0] rdy, output int g);
        bit load;
        int c;
        load = !m_valid || bus.mux_ready;
        g    = -1;
        rdy  = 4'b0000;
        if (bus.mode) begin
            for (int i = 1; i <= N; i++) begin
                c = (m_ptr + i) % N;
                if (g < 0 && bus.din_valid[c]) g = c;
            end
        end else if (int'(bus.sel) < N) begin
            g = int'(bus.sel);
        end
        if (!load || !reset_n) g = -1;
        if (g >= 0) rdy[g] = 1'b1;
    endtask

    // Starts and ends at a falling edge; inputs must already be driven.
    task automatic cycle(input string tag);
        logic [3:0] rdy;
        int         g;
        bit         xfer;
        logic [7:0] d;
        #1;
        model_grant(rdy, g);
        chk({tag, "/din_ready"}, 32'(bus.din_ready), 32'(rdy));
        xfer = (g >= 0) && bus.din_valid[g];
        d    = xfer ? bus.din[g*W +: W] : 8'h00;
        @(posedge clk);
        if (xfer) begin
            m_out   = d;
            m_ch    = g;
            m_valid = 1'b1;
            if (bus.mode) m_ptr = g;
        end else if (m_valid && bus.mux_ready) begin
            m_valid = 1'b0;
        end
        #1;
        chk({tag, "/mux_valid"}, 32'(bus.mux_valid), 32'(m_valid));
        chk({tag, "/mux_out"}, 32'(bus.mux_out), 32'(m_out));
        chk({tag, "/mux_ch"}, 32'(bus.mux_ch), 32'(m_ch));
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        model_reset();
        reset_n        = 1'b0;
        bus.din        = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.din_valid  = 4'hF;
        bus.mode       = 1'b0;
        bus.sel        = 2'd0;
        bus.mux_ready  = 1'b1;
        bus2.din       = {4{8'h5A}};
        bus2.din_valid = 4'hF;
        bus2.mode      = 1'b0;
        bus2.sel       = 3'd5;
        bus2.mux_ready = 1'b1;

        @(negedge clk);
        @(negedge clk);
        chk("reset/mux_valid", 32'(bus.mux_valid), 32'd0);
        chk("reset/mux_out", 32'(bus.mux_out), 32'd0);
        chk("reset/mux_ch", 32'(bus.mux_ch), 32'd0);
        chk("reset/din_ready", 32'(bus.din_ready), 32'd0);
        reset_n = 1'b1;

        // Fixed select of channel 2
        bus.din       = {8'h44, 8'hA5, 8'h22, 8'h11};
        bus.din_valid = 4'b0100;
        bus.sel       = 2'd2;
        cycle("fix_sel2");
        chk("fix_sel2/out", 32'(bus.mux_out), 32'hA5);
        chk("fix_sel2/ch", 32'(bus.mux_ch), 32'd2);
        chk("fix_sel2/valid", 32'(bus.mux_valid), 32'd1);

        // Out-of-range select on the wide-select instance
        for (int s = 4; s < 8; s++) begin
            bus2.sel = 3'(s);
            cycle("wide_oor");
            chk("wide_oor/din_ready", 32'(bus2.din_ready), 32'd0);
            chk("wide_oor/mux_valid", 32'(bus2.mux_valid), 32'd0);
        end
        bus2.sel = 3'd3;
        cycle("wide_sel3");
        chk("wide_sel3/mux_valid", 32'(bus2.mux_valid), 32'd1);
        chk("wide_sel3/mux_ch", 32'(bus2.mux_ch), 32'd3);
        bus2.sel = 3'd5;

        // Round-robin with every channel valid
        bus.mode      = 1'b1;
        bus.din       = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        bus.din_valid = 4'hF;
        for (int i = 0; i < 6; i++) begin
            cycle("rr_all");
            chk("rr_all/seq", 32'(bus.mux_ch), 32'(i % 4));
        end

        // Round-robin with only channels 1 and 3 valid; previous grant was channel 1
        bus.din_valid = 4'b1010;
        for (int i = 0; i < 6; i++) begin
            cycle("rr_odd");
            chk("rr_odd/seq", 32'(bus.mux_ch), (i % 2 == 0) ? 32'd3 : 32'd1);
        end

        // Back-pressure hold
        bus.mode      = 1'b0;
        bus.sel       = 2'd0;
        bus.din       = {8'h00, 8'h00, 8'h00, 8'h3C};
        bus.din_valid = 4'b0001;
        cycle("bp_load");
        bus.mux_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.din       = $urandom;
            bus.din_valid = 4'($urandom_range(0, 15));
            bus.mode      = 1'($urandom_range(0, 1));
            bus.sel       = 2'($urandom_range(0, 3));
            cycle("bp_hold");
            chk("bp_hold/out", 32'(bus.mux_out), 32'h3C);
            chk("bp_hold/din_ready", 32'(bus.din_ready), 32'd0);
        end
        bus.mux_ready = 1'b1;
        bus.mode      = 1'b0;
        bus.sel       = 2'd1;
        bus.din       = {8'h00, 8'h00, 8'h77, 8'h00};
        bus.din_valid = 4'b0010;
        cycle("bp_release");
        chk("bp_release/out", 32'(bus.mux_out), 32'h77);
        chk("bp_release/ch", 32'(bus.mux_ch), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bus.din       = $urandom;
            bus.din_valid = 4'($urandom_range(0, 15));
            bus.mode      = 1'($urandom_range(0, 1));
            bus.sel       = 2'($urandom_range(0, 3));
            bus.mux_ready = ($urandom_range(0, 9) < 7);
            cycle("rand");
        end

        // Reset pulse in the middle of a stream
        bus.mode      = 1'b1;
        bus.din       = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        bus.din_valid = 4'hF;
        bus.mux_ready = 1'b1;
        cycle("pre_rst");
        cycle("pre_rst");
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst/mux_valid", 32'(bus.mux_valid), 32'd0);
        chk("mid_rst/mux_out", 32'(bus.mux_out), 32'd0);
        chk("mid_rst/din_ready", 32'(bus.din_ready), 32'd0);
        chk("mid_rst/wide_valid", 32'(bus2.mux_valid), 32'd0);
        model_reset();
        @(negedge clk);
        reset_n       = 1'b1;
        bus.din_valid = 4'b0110;
        cycle("post_rst");
        chk("post_rst/first_grant", 32'(bus.mux_ch), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
